// File: rtl/parity_pkg.sv
// Shared encodings for the parity unit.
//   par_typ_e  : parity mode selected by PAR_TYP
//   rx_state_e : RX check FSM states
package parity_pkg;

  typedef enum logic [1:0] {
    PAR_EVEN  = 2'b00,
    PAR_ODD   = 2'b01,
    PAR_MARK  = 2'b10,
    PAR_SPACE = 2'b11
  } par_typ_e;

  typedef enum logic [1:0] {
    RX_IDLE   = 2'b00,
    RX_DATA   = 2'b01,
    RX_PAR    = 2'b10,
    RX_REPORT = 2'b11
  } rx_state_e;

endpackage

// File: rtl/parity_core.sv
// Combinational parity generator: value + mode -> expected parity bit.
// Ports:
//   value [WIDTH-1:0] : word whose parity is computed
//   mode  [1:0]       : parity mode (par_typ_e encoding)
//   en                : 0 forces the result to 0
//   par               : resulting parity bit
module parity_core
  import parity_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] value,
  input  logic [1:0]       mode,
  input  logic             en,
  output logic             par
);

  always_comb begin
    par = 1'b0;
    if (en) begin
      unique case (par_typ_e'(mode))
        PAR_EVEN:  par = ^value;
        PAR_ODD:   par = ~(^value);
        PAR_MARK:  par = 1'b1;
        PAR_SPACE: par = 1'b0;
        default:   par = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/parity_unit.sv
// Parity unit: TX parity generation plus serial RX parity check.
// Ports:
//   clk, rst                 : clock, asynchronous active-low reset
//   P_DATA, Data_Valid, busy : TX word, capture strobe, capture blocker
//   PAR_EN, PAR_TYP          : parity enable and mode (shared TX/RX)
//   par_bit                  : registered TX parity bit
//   rx_start, rx_bit, rx_stb : RX frame start, serial bit, bit strobe
//   chk_busy, chk_done       : RX frame in progress, end-of-frame pulse
//   par_err                  : parity mismatch pulse with chk_done
module parity_unit
  import parity_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  busy,
  input  logic                  PAR_EN,
  input  logic [1:0]            PAR_TYP,
  output logic                  par_bit,
  input  logic                  rx_start,
  input  logic                  rx_bit,
  input  logic                  rx_stb,
  output logic                  chk_busy,
  output logic                  chk_done,
  output logic                  par_err
);

  localparam int unsigned   CW       = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(DATA_WIDTH - 1);

  logic            par_q, par_d;
  logic            tx_par;
  rx_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            acc_q, acc_d;
  logic            pen_q, pen_d;
  logic [1:0]      ptyp_q, ptyp_d;
  logic            err_q, err_d;
  logic            rx_exp;

  parity_core #(.WIDTH(DATA_WIDTH)) u_tx_core (
    .value (P_DATA),
    .mode  (PAR_TYP),
    .en    (PAR_EN),
    .par   (tx_par)
  );

  // The accumulator already holds the XOR of all received data bits,
  // so a 1-bit instance yields the expected parity for the latched mode.
  parity_core #(.WIDTH(1)) u_rx_core (
    .value (acc_q),
    .mode  (ptyp_q),
    .en    (1'b1),
    .par   (rx_exp)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_q   <= 1'b0;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      acc_q   <= 1'b0;
      pen_q   <= 1'b0;
      ptyp_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      par_q   <= par_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      pen_q   <= pen_d;
      ptyp_q  <= ptyp_d;
      err_q   <= err_d;
    end
  end

  // TX capture
  always_comb begin
    par_d = par_q;
    if (Data_Valid && !busy) par_d = tx_par;
  end

  // RX next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    pen_d   = pen_q;
    ptyp_d  = ptyp_q;
    err_d   = err_q;
    unique case (state_q)
      RX_IDLE: begin
        if (rx_start) begin
          state_d = RX_DATA;
          cnt_d   = '0;
          acc_d   = 1'b0;
          err_d   = 1'b0;
          pen_d   = PAR_EN;
          ptyp_d  = PAR_TYP;
        end
      end
      RX_DATA: begin
        if (rx_stb) begin
          acc_d = acc_q ^ rx_bit;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST_IDX) state_d = pen_q ? RX_PAR : RX_REPORT;
        end
      end
      RX_PAR: begin
        if (rx_stb) begin
          err_d   = rx_bit ^ rx_exp;
          state_d = RX_REPORT;
        end
      end
      RX_REPORT: state_d = RX_IDLE;
      default:   state_d = RX_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    chk_busy = (state_q == RX_DATA) || (state_q == RX_PAR);
    chk_done = (state_q == RX_REPORT);
    par_err  = (state_q == RX_REPORT) && err_q;
  end

  assign par_bit = par_q;

endmodule

// File: tb/tb_parity_unit.sv
// Self-checking bench for parity_unit (8-bit and 5-bit instances).
module tb_parity_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] P_DATA;
  logic       Data_Valid, busy, PAR_EN;
  logic [1:0] PAR_TYP;
  logic       par_bit;
  logic       rx_start, rx_bit, rx_stb;
  logic       chk_busy, chk_done, par_err;

  logic [4:0] P_DATA5;
  logic       Data_Valid5, busy5, PAR_EN5;
  logic [1:0] PAR_TYP5;
  logic       par_bit5;
  logic       rx_start5, rx_bit5, rx_stb5;
  logic       chk_busy5, chk_done5, par_err5;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  parity_unit #(.DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .P_DATA(P_DATA), .Data_Valid(Data_Valid),
    .busy(busy), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .par_bit(par_bit),
    .rx_start(rx_start), .rx_bit(rx_bit), .rx_stb(rx_stb),
    .chk_busy(chk_busy), .chk_done(chk_done), .par_err(par_err)
  );

  parity_unit #(.DATA_WIDTH(5)) dut5 (
    .clk(clk), .rst(rst), .P_DATA(P_DATA5), .Data_Valid(Data_Valid5),
    .busy(busy5), .PAR_EN(PAR_EN5), .PAR_TYP(PAR_TYP5), .par_bit(par_bit5),
    .rx_start(rx_start5), .rx_bit(rx_bit5), .rx_stb(rx_stb5),
    .chk_busy(chk_busy5), .chk_done(chk_done5), .par_err(par_err5)
  );

  typedef struct {
    logic [7:0] data;
    logic [1:0] typ;
    logic       en;
    logic       dv;
    logic       bsy;
    logic       exp;
  } tx_vec_t;

  tx_vec_t tx_tab[12];

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe8(input logic b);
    rx_bit = b;
    rx_stb = 1'b1;
    tick();
    rx_stb = 1'b0;
  endtask

  task automatic strobe5(input logic b);
    rx_bit5 = b;
    rx_stb5 = 1'b1;
    tick();
    rx_stb5 = 1'b0;
  endtask

  // Sends a word LSB first; with gaps, idles two cycles mid-word and
  // pulses rx_start (must be ignored outside IDLE).
  task automatic send_word8(input logic [7:0] w, input bit gaps);
    for (int i = 0; i < 8; i++) begin
      strobe8(w[i]);
      if (gaps && i == 3) begin
        rx_start = 1'b1;
        tick();
        rx_start = 1'b0;
        tick();
        check("busy_mid_gap", chk_busy, 1'b1);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] w5;

    tx_tab[0]  = '{8'hB9, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1};
    tx_tab[1]  = '{8'hB9, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0};
    tx_tab[2]  = '{8'hB9, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1};
    tx_tab[3]  = '{8'hB9, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0};
    tx_tab[4]  = '{8'hB9, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0};
    tx_tab[5]  = '{8'hB9, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1};
    tx_tab[6]  = '{8'h00, 2'b01, 1'b1, 1'b1, 1'b1, 1'b1};
    tx_tab[7]  = '{8'h00, 2'b01, 1'b1, 1'b1, 1'b0, 1'b1};
    tx_tab[8]  = '{8'h00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0};
    tx_tab[9]  = '{8'hFF, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0};
    tx_tab[10] = '{8'h01, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1};
    tx_tab[11] = '{8'h03, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0};

    rst = 1'b0;
    P_DATA = '0; Data_Valid = 0; busy = 0; PAR_EN = 0; PAR_TYP = '0;
    rx_start = 0; rx_bit = 0; rx_stb = 0;
    P_DATA5 = '0; Data_Valid5 = 0; busy5 = 0; PAR_EN5 = 0; PAR_TYP5 = '0;
    rx_start5 = 0; rx_bit5 = 0; rx_stb5 = 0;
    tick();
    tick();
    check("rst_par_bit", par_bit, 1'b0);
    check("rst_chk_busy", chk_busy, 1'b0);
    check("rst_chk_done", chk_done, 1'b0);
    check("rst_par_err", par_err, 1'b0);
    check("rst_par_bit5", par_bit5, 1'b0);
    rst = 1'b1;
    tick();

    // TX table
    for (int i = 0; i < 12; i++) begin
      P_DATA     = tx_tab[i].data;
      PAR_TYP    = tx_tab[i].typ;
      PAR_EN     = tx_tab[i].en;
      Data_Valid = tx_tab[i].dv;
      busy       = tx_tab[i].bsy;
      tick();
      check($sformatf("tx_vec%0d", i), par_bit, tx_tab[i].exp);
    end
    Data_Valid = 0;
    busy = 0;

    // RX frame A: 0xA5 even, parity 0; mode change after start ignored
    PAR_EN = 1; PAR_TYP = 2'b00;
    rx_start = 1; tick(); rx_start = 0;
    check("a_busy_start", chk_busy, 1'b1);
    PAR_TYP = 2'b01;
    send_word8(8'hA5, 1'b1);
    check("a_busy_par", chk_busy, 1'b1);
    check("a_done_early", chk_done, 1'b0);
    strobe8(1'b0);
    check("a_done", chk_done, 1'b1);
    check("a_err", par_err, 1'b0);
    check("a_busy_report", chk_busy, 1'b0);
    rx_start = 1; tick();
    check("a_done_once", chk_done, 1'b0);
    check("a_report_start_ignored", chk_busy, 1'b0);
    rx_start = 0; tick();
    check("a_idle", chk_busy, 1'b0);

    // RX frame B: 0xA5 even, parity 1 -> error; TX capture on same edge as a strobe
    PAR_EN = 1; PAR_TYP = 2'b00;
    rx_start = 1; tick(); rx_start = 0;
    P_DATA = 8'h01; Data_Valid = 1;
    strobe8(1'b1);
    Data_Valid = 0;
    check("b_tx_concurrent", par_bit, 1'b1);
    for (int i = 1; i < 8; i++) begin
      logic [7:0] w;
      w = 8'hA5;
      strobe8(w[i]);
    end
    strobe8(1'b1);
    check("b_done", chk_done, 1'b1);
    check("b_err", par_err, 1'b1);
    tick();
    check("b_done_clear", chk_done, 1'b0);
    check("b_err_clear", par_err, 1'b0);

    // RX frame C: parity disabled at start, 9th strobe ignored
    PAR_EN = 0; PAR_TYP = 2'b00;
    rx_start = 1; tick(); rx_start = 0;
    PAR_EN = 1;
    send_word8(8'hB9, 1'b0);
    check("c_done", chk_done, 1'b1);
    check("c_err", par_err, 1'b0);
    check("c_busy", chk_busy, 1'b0);
    strobe8(1'b1);
    check("c_ninth_done", chk_done, 1'b0);
    check("c_ninth_busy", chk_busy, 1'b0);
    tick();
    check("c_idle", chk_busy, 1'b0);

    // Reset mid-frame
    PAR_EN = 1; PAR_TYP = 2'b00;
    rx_start = 1; tick(); rx_start = 0;
    strobe8(1'b1); strobe8(1'b1); strobe8(1'b1);
    check("r_busy_before", chk_busy, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("r_busy_async", chk_busy, 1'b0);
    check("r_par_bit_async", par_bit, 1'b0);
    tick();
    check("r_no_done", chk_done, 1'b0);
    rst = 1'b1;
    tick();
    check("r_idle_after", chk_busy, 1'b0);
    rx_start = 1; tick(); rx_start = 0;
    send_word8(8'hA5, 1'b0);
    strobe8(1'b0);
    check("r_done", chk_done, 1'b1);
    check("r_err", par_err, 1'b0);
    tick();

    // DATA_WIDTH=5 instance
    P_DATA5 = 5'b10110; PAR_EN5 = 1; PAR_TYP5 = 2'b10; Data_Valid5 = 1;
    tick();
    check("w5_tx_mark", par_bit5, 1'b1);
    PAR_TYP5 = 2'b01;
    tick();
    check("w5_tx_odd", par_bit5, 1'b0);
    Data_Valid5 = 0;
    rx_start5 = 1; tick(); rx_start5 = 0;
    w5 = 5'b10110;
    for (int i = 0; i < 5; i++) strobe5(w5[i]);
    check("w5_busy_par", chk_busy5, 1'b1);
    strobe5(1'b1);
    check("w5_done", chk_done5, 1'b1);
    check("w5_err", par_err5, 1'b1);
    tick();
    check("w5_done_clear", chk_done5, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
